// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: n iterations per product, start/busy/done handshake, 2n-bit result on hi/lo.
// Optional signed support is compiled in with `define MULT_SIGNED_EN.
module seq_multiplier #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [n-1:0]     m_q, m_d;
    logic [n-1:0]     q_q, q_d;
    logic [n-1:0]     acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [n-1:0]     hi_q, hi_d;
    logic [n-1:0]     lo_q, lo_d;

    logic             accept;
    logic [n-1:0]     load_m;
    logic [n-1:0]     load_q;
    logic [2*n-1:0]   product;
    logic [n-1:0]     addend;
    logic [n:0]       sum;

`ifdef MULT_SIGNED_EN
    logic sign_q;
    logic neg_a;
    logic neg_b;

    assign neg_a   = is_signed & a[n-1];
    assign neg_b   = is_signed & b[n-1];
    // Magnitude of -2^(n-1) wraps to 2^(n-1), which is still correct as an unsigned value.
    assign load_m  = neg_a ? -a : a;
    assign load_q  = neg_b ? -b : b;
    assign product = sign_q ? -{acc_q, q_q} : {acc_q, q_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= neg_a ^ neg_b;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign load_m  = a;
    assign load_q  = b;
    assign product = {acc_q, q_q};
`endif

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign addend = q_q[0] ? m_q : '0;
    assign sum    = {1'b0, acc_q} + {1'b0, addend};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry-out becomes the new MSB of A as {C, A, Q} shifts right.
                acc_d = sum[n:1];
                q_d   = {sum[0], q_q[n-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(n - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d         = 1'b1;
                {hi_d, lo_d}   = product;
                state_d        = start ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            m_d   = load_m;
            q_d   = load_q;
            acc_d = '0;
            cnt_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (n=32): expected products queued at accept, checked on done.
module tb_seq_multiplier;
    localparam int N   = 32;
    localparam int LAT = N + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;

    typedef struct {
        logic [2*N-1:0] prod;
        int unsigned    due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    seq_multiplier #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic s);
        logic   use_signed;
        longint sx;
        longint sy;
        use_signed = s;
`ifndef MULT_SIGNED_EN
        use_signed = 1'b0;
`endif
        if (use_signed) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Done monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("txn hi=0x%08h lo=0x%08h exp=0x%016h cycle=%0d", hi, lo, e.prod, cyc);
                check_val("hi", 64'(hi), 64'(e.prod[2*N-1:N]));
                check_val("lo", 64'(lo), 64'(e.prod[N-1:0]));
                check_val("latency", 64'(cyc), 64'(e.due));
                if (sb.size() == 0) check_val("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 3 * LAT && sb.size() != 0; i++) @(negedge clk);
        check_val("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        exp_t e;
        @(negedge clk);
        start = 1'b1; a = x; b = y; is_signed = s;
        @(posedge clk);
        #1;
        e.prod = model(x, y, s);
        e.due  = cyc + LAT;
        sb.push_back(e);
        check_val("busy_run", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = ~s;
        drain();
    endtask

    initial begin
        exp_t        e;
        int unsigned t0;
        int          done_seen;

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("idle_busy", 64'(busy), 64'd0);
            check_val("idle_done", 64'(done), 64'd0);
            check_val("idle_hi", 64'(hi), 64'd0);
            check_val("idle_lo", 64'(lo), 64'd0);
        end

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Back-to-back with start held high; operands wiggle during RUN
        @(negedge clk);
        start = 1'b1; a = 32'd987654321; b = 32'd123456789; is_signed = 1'b0;
        @(posedge clk);
        #1;
        t0     = cyc;
        e.prod = model(32'd987654321, 32'd123456789, 1'b0);
        e.due  = t0 + LAT;
        sb.push_back(e);
        @(negedge clk);
        a = $urandom; b = $urandom;
        while (cyc < t0 + N) @(negedge clk);
        a = 32'd0; b = 32'h01B3_0FFF;
        @(posedge clk);
        #1;
        e.prod = model(32'd0, 32'h01B3_0FFF, 1'b0);
        e.due  = cyc + LAT;
        check_val("b2b_accept_edge", 64'(cyc), 64'(t0 + LAT));
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        drain();

        // Signed cases (unsigned results expected when the option is compiled out)
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        do_op(32'h8000_0000, 32'd3, 1'b1);
        do_op(32'hFFFF_FFFD, 32'd5, 1'b1);

        for (int i = 0; i < 4; i++) do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        do_op(32'd1, 32'hDEAD_BEEF, 1'b0);
        do_op(32'hFFFF_FFFD, 32'd5, 1'b1);

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_val("no_done_after_reset", 64'(done_seen), 64'd0);
        check_val("idle_after_reset", 64'(busy), 64'd0);

        do_op(32'd12345, 32'd6789, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle shift-and-add multiplier that sits directly upstream of the catalog `adder`. It drives the adder with partial-product operands one bit per cycle and accumulates its sums into a 2n-bit product. The block serves the datapath's HI/LO multiply path, so the CPU needs no combinational n×n array. A start/busy/done handshake lets the control unit stall the pipeline while a multiply is in flight.

## Interface
- `n`, default 32: operand width in bits. Legal values are 4 to 64. The product width is 2n.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a multiply; sampled on the rising edge.
- `is_signed`  in  1  — treat `a`/`b` as two's complement. Only effective with `MULT_SIGNED_EN`.
- `a`  in  n  — multiplicand; latched when `start` is accepted.
- `b`  in  n  — multiplier; latched when `start` is accepted.
- `busy`  out  1  — high while an operation is in progress (RUN state).
- `done`  out  1  — one-cycle pulse; the result is valid on `hi`/`lo`.
- `hi`  out  n  — upper n bits of the product.
- `lo`  out  n  — lower n bits of the product.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: n iterations.
  - DONE: one cycle.
- Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→DONE when the iteration counter reaches n−1.
  - DONE→RUN if `start`=1, otherwise DONE→IDLE.
- On accept, the block latches:
  - multiplicand register M ← `a`;
  - shift register Q ← `b`;
  - accumulator A ← 0;
  - counter ← 0;
  - sign flag (signed build only).
- Each RUN cycle performs one iteration:
  - {C, A} ← A + (Q[0] ? M : 0), an n-bit add with carry-out C;
  - then {C, A, Q} is shifted right by 1;
  - then counter increments.
- After n iterations, {A, Q} holds the 2n-bit unsigned product.
- On entry to DONE, `hi` ← A and `lo` ← Q. These registers hold their value until the next DONE; they do not change during RUN.
- `start` while in RUN is ignored and is not queued.
- There is no early termination. Zero or one operands still take n iterations.
- Arithmetic is exact and cannot overflow the 2n-bit product. The carry out of the adder is kept for the iteration in which it occurs, as the MSB shifted into A.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state = IDLE;
  - `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - counter, M, Q, A = 0.
- Latency: `start` sampled at edge E0 means `busy`=1 from E0 through E(n).
- `done`=1 and the result is valid for exactly one cycle, from edge E(n+1) to edge E(n+2). `busy`=0 during that DONE cycle.
- Throughput with back-to-back `start` held high is one result every n+1 cycles. `start` accepted in DONE begins RUN at the next edge.
- Reset mid-operation:
  - the operation is abandoned;
  - no `done` pulse is produced;
  - `hi`/`lo` go to 0;
  - after reset deasserts, the block stays in IDLE until the next `start`.
- `a`, `b` and `is_signed` may change freely after the accepting edge, because they are latched.

## Configuration
- Macro: `MULT_SIGNED_EN`.
- Defined: when `is_signed`=1 at accept,
  - M and Q are loaded with the absolute values of `a` and `b`;
  - the sign flag is set to a[n−1] XOR b[n−1];
  - in DONE, if the sign flag is set, {hi, lo} is loaded with the two's-complement negation of {A, Q}.
  - This adds no extra cycle; the negation is combinational on the DONE load path.
  - The most-negative operand −2^(n−1) is handled exactly, with its magnitude 2^(n−1) treated as unsigned.
- Undefined: `is_signed` is ignored, all operations are unsigned, and the negation and absolute-value logic is absent.

## Test plan
- Reset then idle, with `start`=0 for 5 cycles:
  - `busy`=0, `done`=0, `hi`=`lo`=0 throughout.
- Unsigned, n=32, `a`=0xFFFFFFFF, `b`=0xFFFFFFFF:
  - `done` pulses exactly 33 cycles after accept;
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Back-to-back, with `start` held high and the pairs 987654321×123456789 then 0×0x01B30FFF:
  - first result `hi`=0x01B13114, `lo`=0xFBFF5385;
  - the second `done` arrives 33 cycles after the first, with `hi`=`lo`=0;
  - `start` pulses during RUN do not alter the results.
- Signed, with `MULT_SIGNED_EN`:
  - −1×−1 gives `hi`=0, `lo`=1;
  - 0x80000000×0x80000000 gives `hi`=0x40000000, `lo`=0;
  - −3×5 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - Without the macro, −3×5 (unsigned 0xFFFFFFFD×5) gives `hi`=0x00000004, `lo`=0xFFFFFFF1.
- Reset mid-RUN: assert `rst_n`=0 at iteration 10.
  - `busy`, `hi` and `lo` drop to 0 immediately;
  - no `done` pulse appears afterward;
  - a new `start` then completes normally.
